// File: rtl/esn_pe_pkg.sv
// esn_pe_pkg: shared word formats, saturation limits and accumulator FSM states
package esn_pe_pkg;
    localparam int WWORD_LEN = 32;
    localparam int SWORD_LEN = 16;
    localparam int QFRAC_W = 21;
    localparam logic [WWORD_LEN-1:0] SAT_POS = 32'h7FFFFFFF;
    localparam logic [WWORD_LEN-1:0] SAT_NEG = 32'h80000000;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
endpackage

// File: rtl/psum_adder_tree.sv
// psum_adder_tree: registered pairwise reduction of NPSUM signed lanes with a matching valid pipe
module psum_adder_tree #(
    parameter int NPSUM = 8,
    parameter int WWORD_LEN = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_ce,
    input  logic                                        i_valid,
    input  logic [NPSUM*WWORD_LEN-1:0]                  i_psum,
    output logic                                        o_valid,
    output logic                                        o_busy,
    output logic signed [WWORD_LEN+$clog2(NPSUM)-1:0]   o_sum
);
    localparam int LVLS = $clog2(NPSUM);
    localparam int TW = WWORD_LEN + LVLS;
    logic signed [TW-1:0] w_leaf [NPSUM];
    logic signed [TW-1:0] r_node [NPSUM-1];
    logic [LVLS-1:0] r_vld;
    always_comb
        for (int k = 0; k < NPSUM; k++)
            w_leaf[k] = TW'(signed'(i_psum[k*WWORD_LEN +: WWORD_LEN]));
    // level l lives at r_node[NPSUM-(NPSUM>>l) +: NPSUM>>(l+1)]; the root is the last entry
    always_ff @(posedge clk)
        if (rst) begin
            r_node <= '{default: '0};
            r_vld <= '0;
        end else if (i_ce) begin
            r_vld <= {r_vld[LVLS-2:0], i_valid};
            for (int l = 0; l < LVLS; l++)
                for (int n = 0; n < (NPSUM >> (l + 1)); n++)
                    if (l == 0)
                        r_node[n] <= w_leaf[2*n] + w_leaf[2*n+1];
                    else
                        r_node[NPSUM-(NPSUM>>l)+n] <= r_node[NPSUM-2*(NPSUM>>l)+2*n]
                                                    + r_node[NPSUM-2*(NPSUM>>l)+2*n+1];
        end
    assign o_sum = r_node[NPSUM-2];
    assign o_valid = r_vld[LVLS-1];
    assign o_busy = |r_vld;
endmodule

// File: rtl/pe_psum_accumulator.sv
// pe_psum_accumulator: reduces PE partial-sum beats through an adder tree into one saturated Q10.21 output
module pe_psum_accumulator
    import esn_pe_pkg::*;
#(
    parameter int WWORD_LEN = 32,
    parameter int NPSUM = 8,
    parameter int ACC_LEN = 40,
    parameter int BEATS_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         start,
    input  logic [BEATS_W-1:0]           num_beats,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NPSUM*WWORD_LEN-1:0]   PSUM,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WWORD_LEN-1:0]         Q,
    output logic                         sat,
    output logic                         busy,
    output logic                         start_err
);
    localparam int TW = WWORD_LEN + $clog2(NPSUM);
    state_t r_state;
    logic [BEATS_W-1:0] r_num, r_cnt;
    logic signed [ACC_LEN-1:0] r_acc;
    logic [WWORD_LEN-1:0] r_q;
    logic r_sat, r_out_valid, r_start_err;
    logic w_tree_valid, w_tree_busy, w_fit;
    logic signed [TW-1:0] w_tree_sum;
    logic [ACC_LEN-WWORD_LEN:0] w_hi;
    logic [WWORD_LEN-1:0] w_q;

    assign in_ready = ce && r_state == ACCUM;
    assign w_hi = r_acc[ACC_LEN-1:WWORD_LEN-1];
    assign w_fit = &w_hi || ~|w_hi;
    assign w_q = w_fit ? r_acc[WWORD_LEN-1:0] : r_acc[ACC_LEN-1] ? SAT_NEG : SAT_POS;

    psum_adder_tree #(.NPSUM(NPSUM), .WWORD_LEN(WWORD_LEN)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_ce    (ce),
        .i_valid (in_valid && in_ready),
        .i_psum  (PSUM),
        .o_valid (w_tree_valid),
        .o_busy  (w_tree_busy),
        .o_sum   (w_tree_sum)
    );

    always_ff @(posedge clk)
        if (rst) begin
            r_state <= IDLE;
            r_num <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_q <= '0;
            r_sat <= 1'b0;
            r_out_valid <= 1'b0;
            r_start_err <= 1'b0;
        end else if (ce) begin
            r_start_err <= start && (r_state != IDLE || num_beats == '0);
            if (w_tree_valid)
                r_acc <= r_acc + ACC_LEN'(w_tree_sum);
            case (r_state)
                IDLE:
                    if (start && num_beats != '0) begin
                        r_num <= num_beats;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_state <= ACCUM;
                    end
                ACCUM:
                    if (in_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == r_num)
                            r_state <= DRAIN;
                    end
                // the tree is empty only once the last beat has been folded into r_acc
                DRAIN:
                    if (!w_tree_busy) begin
                        r_q <= w_q;
                        r_sat <= !w_fit;
                        r_out_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                HOLD:
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state <= IDLE;
                    end
            endcase
        end

    assign Q = r_q;
    assign sat = r_sat;
    assign out_valid = r_out_valid;
    assign busy = r_state != IDLE;
    assign start_err = r_start_err;
endmodule

// File: tb/tb_pe_psum_accumulator.sv
// tb_pe_psum_accumulator: randomized scenario checks of the psum accumulator against an arithmetic model
module tb_pe_psum_accumulator;
    localparam int W = 32;
    localparam int NP = 8;
    localparam int BW = 8;
    typedef logic [NP*W-1:0] beat_t;

    logic clk = 1'b0, rst = 1'b1, ce = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [BW-1:0] num_beats = '0;
    beat_t PSUM = '0;
    logic in_ready, out_valid, sat, busy, start_err;
    logic [W-1:0] Q;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    pe_psum_accumulator #(.WWORD_LEN(W), .NPSUM(NP), .ACC_LEN(40), .BEATS_W(BW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .num_beats(num_beats),
        .in_valid(in_valid), .in_ready(in_ready), .PSUM(PSUM),
        .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .sat(sat),
        .busy(busy), .start_err(start_err)
    );

    function automatic void model(input beat_t b[$], output logic [W-1:0] q, output logic s);
        longint sum = 0;
        foreach (b[i]) begin
            beat_t x = b[i];
            for (int k = 0; k < NP; k++)
                sum += longint'(signed'(x[k*W +: W]));
        end
        s = 1'b1;
        if (sum > 64'sd2147483647) q = 32'h7FFFFFFF;
        else if (sum < -64'sd2147483648) q = 32'h80000000;
        else begin q = W'(sum); s = 1'b0; end
    endfunction

    function automatic beat_t fill(input logic [W-1:0] ev, input logic [W-1:0] od);
        beat_t x;
        for (int k = 0; k < NP; k++) x[k*W +: W] = k % 2 == 0 ? ev : od;
        return x;
    endfunction

    function automatic beat_t rand_beat(input bit big);
        beat_t x;
        for (int k = 0; k < NP; k++) begin
            logic [W-1:0] r = $urandom();
            x[k*W +: W] = big ? r : {{10{r[21]}}, r[21:0]};
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_job(input beat_t b[$], input bit stall, output logic [W-1:0] q,
                           output logic s, output int lat, output int hs_bad);
        int i = 0, guard = 0;
        bit acc;
        hs_bad = 0;
        start = 1'b1;
        num_beats = BW'(b.size());
        step();
        start = 1'b0;
        while (i < b.size() && guard < 1000) begin
            ce = stall ? !ce : 1'b1;
            in_valid = stall ? $urandom_range(0, 3) != 0 : 1'b1;
            PSUM = b[i];
            #1;
            if (in_ready !== ce) hs_bad++;
            acc = ce && in_valid;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        ce = 1'b1;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        q = Q;
        s = sat;
    endtask

    task automatic check_job(input string name, input beat_t b[$], input bit stall);
        logic [W-1:0] eq, q;
        logic es, s;
        int lat, hs;
        model(b, eq, es);
        run_job(b, stall, q, s, lat, hs);
        n_vec++;
        if (lat != 5) begin n_err++; $display("FAIL %s latency: got %0d cycles, expected 5", name, lat); end
        n_vec++;
        if (q !== eq || s !== es) begin
            n_err++;
            $display("FAIL %s result: got Q=%h sat=%b, expected Q=%h sat=%b", name, q, s, eq, es);
        end
        n_vec++;
        if (hs != 0) begin n_err++; $display("FAIL %s in_ready: %0d cycles where in_ready != ce in ACCUM", name, hs); end
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s hold: got busy=%b in_ready=%b, expected 1/0", name, busy, in_ready);
        end
        take();
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s release: got out_valid=%b busy=%b, expected 0/0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_vec++;
        if ({in_ready, out_valid, sat, busy, start_err} !== 5'b0 || Q !== '0) begin
            n_err++;
            $display("FAIL reset: got in_ready=%b out_valid=%b sat=%b busy=%b start_err=%b Q=%h, expected all 0",
                     in_ready, out_valid, sat, busy, start_err, Q);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b in_ready=%b, expected 0/0", busy, in_ready);
        end
    endtask

    task automatic test_idle_ignores_valid();
        in_valid = 1'b1;
        PSUM = fill(32'h00200000, 32'h00200000);
        repeat (3) begin
            step();
            n_vec++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_valid: got in_ready=%b busy=%b, expected 0/0", in_ready, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_unit_lanes();
        beat_t b[$];
        b = '{fill(32'h00200000, 32'h00200000), fill(32'h00200000, 32'h00200000)};
        check_job("unit_lanes", b, 1'b0);
    endtask

    task automatic test_alternating();
        beat_t b[$];
        b = '{fill(32'h00600000, 32'hFFE00000)};
        check_job("alternating", b, 1'b0);
    endtask

    task automatic test_saturation();
        beat_t b[$];
        b = '{4{fill(32'h7FFFFFFF, 32'h7FFFFFFF)}};
        check_job("sat_pos", b, 1'b0);
        b = '{4{fill(32'h80000000, 32'h80000000)}};
        check_job("sat_neg", b, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++) begin
            beat_t b[$];
            int nb = $urandom_range(1, 5);
            bit big = j % 2 == 1;
            for (int i = 0; i < nb; i++) b.push_back(rand_beat(big));
            check_job(big ? "random_big" : "random_small", b, 1'b0);
        end
    endtask

    task automatic test_stall_backpressure();
        beat_t b[$];
        logic [W-1:0] eq, q;
        logic es, s;
        int lat, hs;
        for (int i = 0; i < 3; i++) b.push_back(rand_beat(1'b0));
        model(b, eq, es);
        run_job(b, 1'b1, q, s, lat, hs);
        n_vec++;
        if (q !== eq || s !== es || lat != 5) begin
            n_err++;
            $display("FAIL stall_result: got Q=%h sat=%b lat=%0d, expected Q=%h sat=%b lat=5", q, s, lat, eq, es);
        end
        n_vec++;
        if (hs != 0) begin n_err++; $display("FAIL stall_in_ready: %0d cycles where in_ready != ce", hs); end
        for (int c = 0; c < 10; c++) begin
            start = c == 3;
            num_beats = 8'd2;
            step();
            start = 1'b0;
            n_vec++;
            if (Q !== eq || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure: got Q=%h out_valid=%b in_ready=%b, expected Q=%h 1 0", Q, out_valid, in_ready, eq);
            end
            if (c == 3 || c == 4) begin
                n_vec++;
                if (start_err !== (c == 3)) begin
                    n_err++;
                    $display("FAIL hold_start_err: got %b, expected %b", start_err, c == 3);
                end
            end
        end
        take();
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got out_valid=%b busy=%b, expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_zero_beats();
        start = 1'b1;
        num_beats = '0;
        step();
        start = 1'b0;
        n_vec++;
        if (start_err !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_beats: got start_err=%b busy=%b, expected 1/0", start_err, busy);
        end
        step();
        n_vec++;
        if (start_err !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_beats_pulse: got start_err=%b busy=%b, expected 0/0", start_err, busy);
        end
    endtask

    task automatic test_start_with_take();
        beat_t b[$];
        logic [W-1:0] q;
        logic s;
        int lat, hs;
        b = '{rand_beat(1'b0)};
        run_job(b, 1'b0, q, s, lat, hs);
        start = 1'b1;
        num_beats = 8'd1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || start_err !== 1'b1) begin
            n_err++;
            $display("FAIL start_with_take: got out_valid=%b busy=%b start_err=%b, expected 0/0/1",
                     out_valid, busy, start_err);
        end
        step();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL start_not_taken: got busy=%b, expected 0", busy); end
    endtask

    task automatic test_ce_freeze();
        beat_t b[$];
        logic [W-1:0] q;
        logic s;
        int lat, hs;
        ce = 1'b0;
        start = 1'b1;
        num_beats = 8'd2;
        repeat (2) step();
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || start_err !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ce_idle: got busy=%b start_err=%b in_ready=%b, expected 0/0/0", busy, start_err, in_ready);
        end
        ce = 1'b1;
        b = '{rand_beat(1'b0)};
        run_job(b, 1'b0, q, s, lat, hs);
        ce = 1'b0;
        out_ready = 1'b1;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || Q !== q) begin
            n_err++;
            $display("FAIL ce_hold: got out_valid=%b Q=%h, expected 1 Q=%h", out_valid, Q, q);
        end
        ce = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL ce_resume: got out_valid=%b, expected 0", out_valid); end
    endtask

    task automatic test_abort();
        beat_t b[$];
        bit seen = 0;
        start = 1'b1;
        num_beats = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            PSUM = rand_beat(1'b1);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, sat, busy, start_err} !== 5'b0 || Q !== '0) begin
            n_err++;
            $display("FAIL abort_reset: got in_ready=%b out_valid=%b sat=%b busy=%b start_err=%b Q=%h, expected all 0",
                     in_ready, out_valid, sat, busy, start_err, Q);
        end
        repeat (6) begin
            step();
            if (out_valid !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL abort_output: got out_valid=1 after reset, expected 0"); end
        b = '{fill(32'h00200000, 32'h00200000)};
        check_job("after_abort", b, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_ignores_valid();
        test_unit_lanes();
        test_alternating();
        test_saturation();
        test_back_to_back();
        test_stall_backpressure();
        test_zero_beats();
        test_start_with_take();
        test_ce_freeze();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
